// File: rtl/tlb_pkg.sv
// Shared types and constants for the TLB instruction sequencer.
// Imported by tlb_random and tlb_ctrl.
package tlb_pkg;

    localparam int TLB_ENTRIES = 16;
    localparam int TLB_IW      = $clog2(TLB_ENTRIES);

    typedef enum logic [1:0] {
        TLBP  = 2'd0,
        TLBR  = 2'd1,
        TLBWI = 2'd2,
        TLBWR = 2'd3
    } tlb_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } tlbctrl_state_e;

    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        logic        g;
    } tlb_lo_t;

endpackage

// File: rtl/tlb_random.sv
// CP0 Random/Wired register pair.
// Random counts down each cycle and wraps to the top entry after Wired.
module tlb_random
    import tlb_pkg::*;
#(
    parameter int TLBNUM = TLB_ENTRIES,
    parameter int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wired_we,
    input  logic [IW-1:0] wired_wdata,
    output logic [IW-1:0] random_q,
    output logic [IW-1:0] wired_q
);

    localparam logic [IW-1:0] TOP = IW'(TLBNUM - 1);

    // Wired write restarts Random at the top; otherwise count down to Wired
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            random_q <= TOP;
            wired_q  <= '0;
        end else if (wired_we) begin
            wired_q  <= wired_wdata;
            random_q <= TOP;
        end else if (random_q == wired_q) begin
            random_q <= TOP;
        end else begin
            random_q <= random_q - 1'b1;
        end
    end

endmodule

// File: rtl/tlb_ctrl.sv
// TLBP/TLBR/TLBWI/TLBWR sequencer with search-port-1 arbitration.
// Owns Random/Wired through tlb_random.
module tlb_ctrl
    import tlb_pkg::*;
#(
    parameter int TLBNUM = TLB_ENTRIES,
    parameter int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          op_valid,
    input  logic [1:0]    op_type,
    output logic          op_ready,
    output logic          op_done,
    input  logic [18:0]   ehi_vpn2,
    input  logic [7:0]    ehi_asid,
    input  logic [25:0]   elo0,
    input  logic [25:0]   elo1,
    input  logic [IW-1:0] cp0_index,
    input  logic          wired_we,
    input  logic [IW-1:0] wired_wdata,
    output logic [IW-1:0] random_q,
    output logic [IW-1:0] wired_q,
    input  logic [18:0]   dm_vpn2,
    input  logic [7:0]    dm_asid,
    output logic          dm_stall,
    output logic [18:0]   s1_vpn2,
    output logic [7:0]    s1_asid,
    input  logic          s1_found,
    input  logic [IW-1:0] s1_index,
    output logic          tlb_we,
    output logic [IW-1:0] tlb_w_index,
    output logic [18:0]   tlb_w_vpn2,
    output logic [7:0]    tlb_w_asid,
    output logic          tlb_w_g,
    output logic [19:0]   tlb_w_pfn0,
    output logic [2:0]    tlb_w_c0,
    output logic          tlb_w_d0,
    output logic          tlb_w_v0,
    output logic [19:0]   tlb_w_pfn1,
    output logic [2:0]    tlb_w_c1,
    output logic          tlb_w_d1,
    output logic          tlb_w_v1,
    output logic [IW-1:0] tlb_r_index,
    input  logic [18:0]   tlb_r_vpn2,
    input  logic [7:0]    tlb_r_asid,
    input  logic          tlb_r_g,
    input  logic [19:0]   tlb_r_pfn0,
    input  logic [2:0]    tlb_r_c0,
    input  logic          tlb_r_d0,
    input  logic          tlb_r_v0,
    input  logic [19:0]   tlb_r_pfn1,
    input  logic [2:0]    tlb_r_c1,
    input  logic          tlb_r_d1,
    input  logic          tlb_r_v1,
    output logic          cp0_index_we,
    output logic [31:0]   cp0_index_wdata,
    output logic          cp0_entry_we,
    output logic [18:0]   rd_vpn2,
    output logic [7:0]    rd_asid,
    output logic [25:0]   rd_elo0,
    output logic [25:0]   rd_elo1
);

    tlbctrl_state_e state;
    tlb_op_e        op_q;
    tlb_op_e        op_in;
    logic [IW-1:0]  rand_idx_q;
    logic           tlbp_exec;
    tlb_lo_t        lo0;
    tlb_lo_t        lo1;

    tlb_random #(
        .TLBNUM (TLBNUM),
        .IW     (IW)
    ) u_random (
        .clk         (clk),
        .resetn      (resetn),
        .wired_we    (wired_we),
        .wired_wdata (wired_wdata),
        .random_q    (random_q),
        .wired_q     (wired_q)
    );

    assign op_in     = tlb_op_e'(op_type);
    assign tlbp_exec = (state == S_EXEC) && (op_q == TLBP);

    // TLBP borrows port 1 for its EXEC cycle; data side owns it otherwise
    assign s1_vpn2 = tlbp_exec ? ehi_vpn2 : dm_vpn2;
    assign s1_asid = tlbp_exec ? ehi_asid : dm_asid;

    assign tlb_r_index = cp0_index;

    assign lo0 = elo0;
    assign lo1 = elo1;

    // TLBWR uses the Random value captured at acceptance
    assign tlb_w_index = (op_q == TLBWR) ? rand_idx_q : cp0_index;
    assign tlb_w_vpn2  = ehi_vpn2;
    assign tlb_w_asid  = ehi_asid;
    assign tlb_w_g     = lo0.g & lo1.g;
    assign tlb_w_pfn0  = lo0.pfn;
    assign tlb_w_c0    = lo0.c;
    assign tlb_w_d0    = lo0.d;
    assign tlb_w_v0    = lo0.v;
    assign tlb_w_pfn1  = lo1.pfn;
    assign tlb_w_c1    = lo1.c;
    assign tlb_w_d1    = lo1.d;
    assign tlb_w_v1    = lo1.v;

    // IDLE -> EXEC -> RESP sequencer with registered strobes and results
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= S_IDLE;
            op_q            <= TLBP;
            rand_idx_q      <= '0;
            op_ready        <= 1'b1;
            op_done         <= 1'b0;
            tlb_we          <= 1'b0;
            dm_stall        <= 1'b0;
            cp0_index_we    <= 1'b0;
            cp0_entry_we    <= 1'b0;
            cp0_index_wdata <= '0;
            rd_vpn2         <= '0;
            rd_asid         <= '0;
            rd_elo0         <= '0;
            rd_elo1         <= '0;
        end else begin
            op_done      <= 1'b0;
            tlb_we       <= 1'b0;
            dm_stall     <= 1'b0;
            cp0_index_we <= 1'b0;
            cp0_entry_we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (op_valid && op_ready) begin
                        state      <= S_EXEC;
                        op_ready   <= 1'b0;
                        op_q       <= op_in;
                        rand_idx_q <= random_q;
                        tlb_we     <= (op_in == TLBWI) || (op_in == TLBWR);
                        dm_stall   <= (op_in == TLBP);
                    end
                end
                S_EXEC: begin
                    state   <= S_RESP;
                    op_done <= 1'b1;
                    unique case (op_q)
                        TLBP: begin
                            cp0_index_we <= 1'b1;
                            cp0_index_wdata <= s1_found
                                ? {{(32-IW){1'b0}}, s1_index}
                                : 32'h8000_0000;
                        end
                        TLBR: begin
                            cp0_entry_we <= 1'b1;
                            rd_vpn2 <= tlb_r_vpn2;
                            rd_asid <= tlb_r_asid;
                            rd_elo0 <= {tlb_r_pfn0, tlb_r_c0,
                                        tlb_r_d0, tlb_r_v0, tlb_r_g};
                            rd_elo1 <= {tlb_r_pfn1, tlb_r_c1,
                                        tlb_r_d1, tlb_r_v1, tlb_r_g};
                        end
                        default: ;
                    endcase
                end
                S_RESP: begin
                    state    <= S_IDLE;
                    op_ready <= 1'b1;
                end
                default: begin
                    state    <= S_IDLE;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
